ring_history_buffer: RTL

RING_HISTORY_BUFFER -- requirements
Module: ring_history_buffer

---
 rtl/ring_buf_pkg.sv | 14 +
 rtl/ring_buf_mem.sv | 26 ++
 rtl/ring_history_buffer.sv | 127 ++++++++++++
 3 files changed

// File: rtl/ring_buf_pkg.sv
// Shared types and constants for the ring history buffer.
// Imported by the control and storage modules.
package ring_buf_pkg;

  localparam int WR_TOTAL_W = 16;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_FILLING,
    ST_FULL,
    ST_HALTED
  } rb_state_e;

endpackage

// File: rtl/ring_buf_mem.sv
// History storage: one write port, one registered read port.
// Contents are never reset; a same-address read returns old data.
module ring_buf_mem
  import ring_buf_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/ring_history_buffer.sv
// Ring history buffer control: FSM, pointers, count, flags.
// Reads address entries by age relative to the latest write.
module ring_history_buffer
  import ring_buf_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  mode,
  input  logic                  wr_en,
  input  logic [DATA_W-1:0]     data_in,
  input  logic                  rd_en,
  input  logic [AW-1:0]         rd_offset,
  output logic [DATA_W-1:0]     data_out,
  output logic                  rd_valid,
  output logic                  rd_err,
  output logic [AW:0]           count,
  output logic                  full,
  output logic                  wrapped,
  output logic                  overflow,
  output logic [WR_TOTAL_W-1:0] wr_total
);

  localparam logic [AW:0] CNT_MAX = (AW+1)'(DEPTH);

  rb_state_e         state_q, state_d;
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              have_rd;
  logic              wr_acc;
  logic              wr_drop;
  logic              rd_in_range;
  logic              rd_ok;
  logic              rd_bad;

  assign wr_acc  = wr_en && !clear && (state_q != ST_HALTED);
  assign wr_drop = wr_en && !clear && (state_q == ST_HALTED);

  assign rd_in_range = ({1'b0, rd_offset} < count);
  assign rd_ok       = rd_en && !clear && rd_in_range;
  assign rd_bad      = rd_en && !clear && !rd_in_range;

  // Age 0 is the slot just behind the write pointer
  assign rd_addr = wr_ptr - AW'(1) - rd_offset;

  assign full = (count == CNT_MAX);

  // Memory read register only loads on good reads, so it holds on errors
  assign data_out = have_rd ? mem_rdata : '0;

  ring_buf_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr),
    .wdata (data_in),
    .re    (rd_ok),
    .raddr (rd_addr),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_EMPTY;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_EMPTY: begin
        if (wr_acc) state_d = ST_FILLING;
      end
      ST_FILLING: begin
        if (wr_acc && (count == CNT_MAX - 1'b1))
          state_d = mode ? ST_HALTED : ST_FULL;
      end
      ST_FULL: begin
        if (mode) state_d = ST_HALTED;
      end
      ST_HALTED: begin
        if (!mode) state_d = ST_FULL;
      end
      default: state_d = ST_EMPTY;
    endcase
    if (clear) state_d = ST_EMPTY;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      count    <= '0;
      wr_total <= '0;
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
      wrapped  <= 1'b0;
      overflow <= 1'b0;
      have_rd  <= 1'b0;
    end else begin
      rd_valid <= rd_ok;
      rd_err   <= rd_bad;
      if (rd_ok) have_rd <= 1'b1;
      if (clear) begin
        wr_ptr   <= '0;
        count    <= '0;
        wrapped  <= 1'b0;
        overflow <= 1'b0;
      end else begin
        if (wr_acc) begin
          wr_ptr   <= wr_ptr + 1'b1;
          wr_total <= wr_total + 1'b1;
          if (count != CNT_MAX) count <= count + 1'b1;
          else                  wrapped <= 1'b1;
        end
        if (wr_drop) overflow <= 1'b1;
      end
    end
  end

endmodule
